// File: rtl/dpll_loop_ctrl.sv
// Digital PLL loop controller: K-counter phase filter steering a clamped DCO period,
// a phase counter generating the DCO tick, and an IDLE/ACQUIRE/LOCKED lock detector.
module dpll_loop_ctrl #(
  parameter int K_MAX    = 16,
  parameter int N_W      = 16,
  parameter int N_NOM    = 1000,
  parameter int N_MIN    = 900,
  parameter int N_MAX    = 1100,
  parameter int LOCK_WIN = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           enable_i,
  input  logic           forwarding_i,
  input  logic           slowing_i,
  output logic [N_W-1:0] period_o,
  output logic           tick_o,
  output logic           carry_o,
  output logic           borrow_o,
  output logic           locked_o,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam int KW = $clog2(K_MAX + 1) + 1;
  localparam int QW = $clog2(LOCK_WIN + 1);

  localparam logic signed [KW-1:0] K_POS = KW'(K_MAX);
  localparam logic signed [KW-1:0] K_NEG = -K_POS;
  localparam logic signed [KW-1:0] K_ONE = KW'(1);
  localparam logic [N_W-1:0] P_NOM = N_W'(N_NOM);
  localparam logic [N_W-1:0] P_MIN = N_W'(N_MIN);
  localparam logic [N_W-1:0] P_MAX = N_W'(N_MAX);
  localparam logic [N_W-1:0] P_ONE = N_W'(1);
  localparam logic [QW-1:0]  Q_WIN = QW'(LOCK_WIN);
  localparam logic [QW-1:0]  Q_ONE = QW'(1);

  state_t                state, state_nxt;
  logic signed [KW-1:0]  kcnt, k_sum;
  logic [N_W-1:0]        phase, period_dec, period_inc;
  logic [QW-1:0]         quiet;
  logic                  run, hit_pos, hit_neg, wrap, pulse;

  always_comb begin
    run   = enable_i && (state != S_IDLE);
    pulse = carry_o | borrow_o;
    k_sum = kcnt;
    if (forwarding_i && !slowing_i)
      k_sum = kcnt + K_ONE;
    else if (slowing_i && !forwarding_i)
      k_sum = kcnt - K_ONE;
    hit_pos    = (k_sum == K_POS);
    hit_neg    = (k_sum == K_NEG);
    // >= rather than == so a period that just shrank below the count still wraps
    wrap       = (phase >= period_o - P_ONE);
    period_dec = (period_o > P_MIN) ? period_o - P_ONE : P_MIN;
    period_inc = (period_o < P_MAX) ? period_o + P_ONE : P_MAX;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable_i) state_nxt = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (!enable_i)                   state_nxt = S_IDLE;
        else if (!pulse && quiet == Q_WIN) state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        if (!enable_i)  state_nxt = S_IDLE;
        else if (pulse) state_nxt = S_ACQUIRE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      period_o <= P_NOM;
      kcnt     <= '0;
      phase    <= '0;
      quiet    <= '0;
      tick_o   <= 1'b0;
      carry_o  <= 1'b0;
      borrow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!run) begin
        kcnt     <= '0;
        phase    <= '0;
        quiet    <= '0;
        tick_o   <= 1'b0;
        carry_o  <= 1'b0;
        borrow_o <= 1'b0;
      end else begin
        kcnt     <= (hit_pos || hit_neg) ? '0 : k_sum;
        carry_o  <= hit_pos;
        borrow_o <= hit_neg;
        if (hit_pos)
          period_o <= period_dec;
        else if (hit_neg)
          period_o <= period_inc;
        phase  <= wrap ? '0 : phase + P_ONE;
        tick_o <= wrap;
        // a correction always wins over a coincident quiet tick
        if (pulse)
          quiet <= '0;
        else if (state == S_ACQUIRE && tick_o && quiet != Q_WIN)
          quiet <= quiet + Q_ONE;
      end
    end
  end

  assign state_o  = state;
  assign locked_o = (state == S_LOCKED);

endmodule

// File: doc/dpll_loop_ctrl.md
DPLL_LOOP_CTRL -- requirements
Module: dpll_loop_ctrl

Interface
REQ-001 The block SHALL have parameter K_MAX, default 16: net phase-detector pulse count that triggers one period correction.
REQ-002 The block SHALL have parameter N_W, default 16: width of the period value and the phase counter.
REQ-003 The block SHALL have parameters N_NOM 1000, N_MIN 900 and N_MAX 1100: nominal, minimum and maximum DCO period in clk_i cycles.
REQ-004 The block SHALL have parameter LOCK_WIN, default 8: number of consecutive correction-free ticks needed to declare lock.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-006 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port enable_i, input, 1 bit: loop run request.
REQ-008 The block SHALL have ports forwarding_i and slowing_i, inputs, 1 bit each: phase-detector outputs, sampled every cycle.
REQ-009 The block SHALL have port period_o, output, N_W bits: current DCO period.
REQ-010 The block SHALL have port tick_o, output, 1 bit: one-cycle DCO output pulse.
REQ-011 The block SHALL have ports carry_o and borrow_o, outputs, 1 bit each: one-cycle pulses marking a period decrement or increment event.
REQ-012 The block SHALL have port locked_o, output, 1 bit: loop-locked flag.
REQ-013 The block SHALL have port state_o, output, 2 bits: FSM state, encoded IDLE=0, ACQUIRE=1, LOCKED=2.

Function
REQ-014 The K-counter SHALL be a signed accumulator holding -K_MAX..+K_MAX.
REQ-015 The K-counter SHALL step +1 when forwarding_i=1 and slowing_i=0, and -1 when slowing_i=1 and forwarding_i=0.
REQ-016 The K-counter SHALL hold its value when forwarding_i and slowing_i are both 0 or both 1.
REQ-017 When the K-counter's next value equals +K_MAX, it SHALL load 0, carry_o SHALL be 1 for the following cycle, and period_o SHALL decrement by 1 on the same edge.
REQ-018 When the K-counter's next value equals -K_MAX, it SHALL load 0, borrow_o SHALL be 1 for the following cycle, and period_o SHALL increment by 1 on the same edge.
REQ-019 period_o SHALL saturate at N_MIN and N_MAX; carry_o and borrow_o SHALL still pulse when the period is clamped.
REQ-020 The phase counter SHALL count 0..period_o-1 in ACQUIRE and LOCKED.
REQ-021 When the phase counter is >= period_o-1, it SHALL wrap to 0 on the next edge and tick_o SHALL be 1 for one cycle; this covers a period that shrinks below the current count.
REQ-022 IDLE->ACQUIRE SHALL occur on the first edge with enable_i=1.
REQ-023 Any state SHALL go to IDLE on the first edge with enable_i=0.
REQ-024 In IDLE, the K-counter, phase counter and quiet counter SHALL be cleared, period_o SHALL hold its value, and tick_o, carry_o, borrow_o and locked_o SHALL be 0.
REQ-025 In ACQUIRE, the quiet counter SHALL increment on each tick_o cycle in which carry_o and borrow_o are both 0.
REQ-026 The quiet counter SHALL clear on any carry_o or borrow_o; a carry or borrow coinciding with tick_o SHALL clear it.
REQ-027 ACQUIRE->LOCKED SHALL occur on the edge after the quiet counter reaches LOCK_WIN.
REQ-028 LOCKED->ACQUIRE SHALL occur on the edge after any carry_o or borrow_o, and the quiet counter SHALL clear at that transition.
REQ-029 locked_o SHALL be 1 exactly when the state is LOCKED.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 When reset_i=1 at a rising edge of clk_i, state_o SHALL become IDLE, period_o SHALL become N_NOM, all internal counters SHALL become 0, and tick_o, carry_o, borrow_o and locked_o SHALL become 0.
REQ-032 reset_i SHALL take priority over enable_i and over all other inputs, including mid-operation.

Verification (default parameters)
REQ-033 The bench SHALL cover: reset, then enable_i=1 with no phase-detector pulses -> tick_o every 1000 cycles; the 8th tick is followed by locked_o=1 and state_o=2.
REQ-034 The bench SHALL cover: 16 consecutive forwarding_i cycles -> carry_o pulses once, the cycle after the 16th; period_o becomes 999; no second carry_o.
REQ-035 The bench SHALL cover: 40 cycles alternating forwarding_i/slowing_i, and 20 cycles with both inputs high -> no carry_o or borrow_o; period_o stays 1000.
REQ-036 The bench SHALL cover: period_o driven down to 900, then 16 more forwarding_i cycles -> carry_o pulses, period_o stays 900; the next 16 slowing_i cycles give borrow_o and period_o=901.
REQ-037 The bench SHALL cover: in LOCKED, 16 slowing_i cycles -> borrow_o, then state_o=1 and locked_o=0 on the next edge.
REQ-038 The bench SHALL cover: in LOCKED with period 995, enable_i=0 -> state_o=0 and period_o stays 995; then reset_i=1 for 1 cycle -> period_o=1000 and all pulse outputs 0.
